// File: rtl/hit_pattern_gen.sv
// Multi-layer hit stimulus generator: per-layer {timestamp, hit} tables replayed
// against a shared timestamp counter, with optional periodic looping.
module hit_pattern_gen #(
    parameter int N_LAYERS = 6,
    parameter int HIT_W    = 24,
    parameter int TS_W     = 32,
    parameter int DEPTH    = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int LW      = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_mode,
    input  logic [TS_W-1:0]           loop_len,
    input  logic                      wr_en,
    input  logic [LW-1:0]             wr_layer,
    input  logic [AW-1:0]             wr_addr,
    input  logic                      wr_last,
    input  logic [TS_W-1:0]           wr_ts,
    input  logic [HIT_W-1:0]          wr_hit,
    output logic [N_LAYERS-1:0]       hit_dv,
    output logic [N_LAYERS*HIT_W-1:0] hit_data,
    output logic [TS_W-1:0]           ts_cnt,
    output logic                      busy,
    output logic                      done,
    output logic [N_LAYERS-1:0]       err_skip
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [TS_W-1:0] TS_ONE = 1;

    state_t                           state_q, state_d;
    logic [TS_W-1:0]                  ts_q, ts_d;
    logic [AW:0]                      ptr_q [N_LAYERS];
    logic [AW:0]                      ptr_d [N_LAYERS];
    logic [AW:0]                      cnt_q [N_LAYERS];
    logic [AW:0]                      cnt_d [N_LAYERS];
    logic [N_LAYERS-1:0]              err_q, err_d;
    logic [N_LAYERS-1:0]              dv_q, dv_d;
    logic [N_LAYERS-1:0][HIT_W-1:0]   data_q, data_d;

    logic [TS_W-1:0]                  ts_mem  [N_LAYERS][DEPTH];
    logic [HIT_W-1:0]                 hit_mem [N_LAYERS][DEPTH];

    logic                             wr_ok;
    logic                             all_fin;
    logic                             loop_wrap;
    logic [TS_W-1:0]                  e_ts;

    assign wr_ok     = wr_en && (state_q == S_IDLE) && (int'(wr_layer) < N_LAYERS);
    assign loop_wrap = loop_mode && (loop_len != '0) && (ts_q == loop_len - TS_ONE);

    // Table storage carries no reset; an empty count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ts_mem[wr_layer][wr_addr]  <= wr_ts;
            hit_mem[wr_layer][wr_addr] <= wr_hit;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        all_fin = 1'b1;
        if (wr_ok && wr_last) begin
            cnt_d[wr_layer] = {1'b0, wr_addr} + PTR_ONE;
        end
        for (int k = 0; k < N_LAYERS; k++) begin
            if (ptr_q[k] != cnt_q[k]) all_fin = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        dv_d    = '0;
        data_d  = '0;
        e_ts    = '0;
        if (stop) begin
            state_d = S_IDLE;
            ts_d    = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_IDLE) ts_d = '0;
                    if (start) begin
                        state_d = S_RUN;
                        ts_d    = '0;
                        err_d   = '0;
                        for (int k = 0; k < N_LAYERS; k++) ptr_d[k] = '0;
                    end
                end
                S_RUN: begin
                    if (all_fin && !loop_mode) begin
                        state_d = S_DONE;
                    end else if (en) begin
                        // Each layer consumes at most one entry per cycle: emit on match, drop if stale.
                        for (int k = 0; k < N_LAYERS; k++) begin
                            if (ptr_q[k] < cnt_q[k]) begin
                                e_ts = ts_mem[k][ptr_q[k][AW-1:0]];
                                if (e_ts == ts_q) begin
                                    dv_d[k]   = 1'b1;
                                    data_d[k] = hit_mem[k][ptr_q[k][AW-1:0]];
                                    ptr_d[k]  = ptr_q[k] + PTR_ONE;
                                end else if (e_ts < ts_q) begin
                                    ptr_d[k]  = ptr_q[k] + PTR_ONE;
                                    err_d[k]  = 1'b1;
                                end
                            end
                        end
                        ts_d = ts_q + TS_ONE;
                        if (loop_wrap) begin
                            ts_d = '0;
                            for (int k = 0; k < N_LAYERS; k++) ptr_d[k] = '0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ts_q    <= '0;
            err_q   <= '0;
            dv_q    <= '0;
            data_q  <= '0;
            for (int k = 0; k < N_LAYERS; k++) begin
                ptr_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hit_dv   = dv_q;
    assign hit_data = data_q;
    assign ts_cnt   = ts_q;
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign err_skip = err_q;

endmodule

// File: tb/tb_hit_pattern_gen.sv
// Directed bench for hit_pattern_gen: replay timing, multi-layer, skip, pause, loop and control.
module tb_hit_pattern_gen;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         loop_mode = 1'b0;
    logic [31:0]  loop_len = '0;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_layer = '0;
    logic [3:0]   wr_addr = '0;
    logic         wr_last = 1'b0;
    logic [31:0]  wr_ts = '0;
    logic [23:0]  wr_hit = '0;
    logic [5:0]   hit_dv;
    logic [143:0] hit_data;
    logic [31:0]  ts_cnt;
    logic         busy;
    logic         done;
    logic [5:0]   err_skip;

    int checks = 0;
    int failures = 0;

    hit_pattern_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .loop_mode(loop_mode), .loop_len(loop_len),
        .wr_en(wr_en), .wr_layer(wr_layer), .wr_addr(wr_addr), .wr_last(wr_last),
        .wr_ts(wr_ts), .wr_hit(wr_hit),
        .hit_dv(hit_dv), .hit_data(hit_data), .ts_cnt(ts_cnt),
        .busy(busy), .done(done), .err_skip(err_skip)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wr(input int layer, input int addr, input logic [31:0] ts,
                      input logic [23:0] hit, input logic last);
        wr_en    = 1'b1;
        wr_layer = 3'(layer);
        wr_addr  = 4'(addr);
        wr_ts    = ts;
        wr_hit   = hit;
        wr_last  = last;
        tick(1);
        wr_en    = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(1);
        chk("rst_dv", 64'(hit_dv), 64'h0);
        chk("rst_data", 64'(|hit_data), 64'h0);
        chk("rst_ts", 64'(ts_cnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err_skip), 64'h0);
        rst_n = 1'b1;
        tick(1);

        // T1 basic replay on layer 0
        wr(0, 0, 32'd5, 24'hABCDEF, 1'b0);
        wr(0, 1, 32'd9, 24'h000001, 1'b1);
        pulse_start();
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_ts0", 64'(ts_cnt), 64'h0);
        tick(5);
        chk("t1_dv_ts5", 64'(hit_dv), 64'h0);
        tick(1);
        chk("t1_ts6", 64'(ts_cnt), 64'd6);
        chk("t1_dv_a", 64'(hit_dv), 64'h01);
        chk("t1_data_a", 64'(hit_data[23:0]), 64'hABCDEF);
        tick(1);
        chk("t1_dv_pulse", 64'(hit_dv), 64'h0);
        chk("t1_data_clr", 64'(hit_data[23:0]), 64'h0);
        tick(3);
        chk("t1_ts10", 64'(ts_cnt), 64'd10);
        chk("t1_dv_b", 64'(hit_dv), 64'h01);
        chk("t1_data_b", 64'(hit_data[23:0]), 64'h000001);
        tick(1);
        chk("t1_done", 64'(done), 64'h1);
        chk("t1_busy_off", 64'(busy), 64'h0);
        chk("t1_ts_hold", 64'(ts_cnt), 64'd10);
        chk("t1_dv_idle", 64'(hit_dv), 64'h0);

        // T2 simultaneous hits on layers 0 and 5
        do_reset();
        wr(0, 0, 32'd3, 24'h111111, 1'b1);
        wr(5, 0, 32'd3, 24'h555555, 1'b1);
        pulse_start();
        tick(3);
        chk("t2_dv_ts3", 64'(hit_dv), 64'h0);
        tick(1);
        chk("t2_dv", 64'(hit_dv), 64'b100001);
        chk("t2_data0", 64'(hit_data[23:0]), 64'h111111);
        chk("t2_data5", 64'(hit_data[5*24 +: 24]), 64'h555555);
        chk("t2_mid_zero", 64'(|hit_data[5*24-1:24]), 64'h0);
        tick(1);
        chk("t2_done", 64'(done), 64'h1);

        // T3 duplicate timestamp is skipped and flagged
        do_reset();
        wr(1, 0, 32'd4, 24'hAAAAAA, 1'b0);
        wr(1, 1, 32'd4, 24'hBBBBBB, 1'b0);
        wr(1, 2, 32'd7, 24'hCCCCCC, 1'b1);
        pulse_start();
        tick(5);
        chk("t3_dv_a", 64'(hit_dv), 64'b000010);
        chk("t3_data_a", 64'(hit_data[24 +: 24]), 64'hAAAAAA);
        chk("t3_err_pre", 64'(err_skip), 64'h0);
        tick(1);
        chk("t3_dv_skip", 64'(hit_dv), 64'h0);
        chk("t3_err", 64'(err_skip), 64'b000010);
        tick(2);
        chk("t3_ts8", 64'(ts_cnt), 64'd8);
        chk("t3_dv_c", 64'(hit_dv), 64'b000010);
        chk("t3_data_c", 64'(hit_data[24 +: 24]), 64'hCCCCCC);
        tick(1);
        chk("t3_done", 64'(done), 64'h1);
        chk("t3_err_sticky", 64'(err_skip), 64'b000010);

        // T4 pause holds the timestamp
        do_reset();
        wr(2, 0, 32'd5, 24'h123456, 1'b1);
        pulse_start();
        tick(4);
        en = 1'b0;
        tick(3);
        chk("t4_ts_hold", 64'(ts_cnt), 64'd4);
        chk("t4_dv_hold", 64'(hit_dv), 64'h0);
        en = 1'b1;
        tick(1);
        chk("t4_ts5", 64'(ts_cnt), 64'd5);
        chk("t4_dv_ts5", 64'(hit_dv), 64'h0);
        tick(1);
        chk("t4_dv", 64'(hit_dv), 64'b000100);
        chk("t4_data", 64'(hit_data[2*24 +: 24]), 64'h123456);

        // T5 periodic replay with loop_len 8
        do_reset();
        wr(3, 0, 32'd7, 24'h0F0F0F, 1'b1);
        loop_mode = 1'b1;
        loop_len  = 32'd8;
        pulse_start();
        for (int i = 1; i <= 32; i++) begin
            tick(1);
            chk($sformatf("t5_ts_%0d", i), 64'(ts_cnt), 64'(i % 8));
            chk($sformatf("t5_dv_%0d", i), 64'(hit_dv), (i % 8 == 0) ? 64'b001000 : 64'h0);
        end
        chk("t5_data", 64'(hit_data[3*24 +: 24]), 64'h0F0F0F);
        chk("t5_done", 64'(done), 64'h0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("t5_stop_busy", 64'(busy), 64'h0);
        chk("t5_stop_ts", 64'(ts_cnt), 64'h0);
        loop_mode = 1'b0;
        loop_len  = '0;

        // T6 control: start+stop, ignored write in RUN, async reset mid-run
        do_reset();
        wr(4, 0, 32'd6, 24'h444444, 1'b1);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("t6_startstop", 64'(busy), 64'h0);
        pulse_start();
        chk("t6_run", 64'(busy), 64'h1);
        wr(4, 0, 32'd2, 24'h999999, 1'b1);
        tick(2);
        chk("t6_ts3", 64'(ts_cnt), 64'd3);
        chk("t6_no_wr_hit", 64'(hit_dv), 64'h0);
        tick(4);
        chk("t6_dv", 64'(hit_dv), 64'b010000);
        chk("t6_data", 64'(hit_data[4*24 +: 24]), 64'h444444);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dv", 64'(hit_dv), 64'h0);
        chk("t6_rst_data", 64'(|hit_data), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        chk("t6_rst_ts", 64'(ts_cnt), 64'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
